// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad row/column lines plus the decoded row/column status bus.
interface keypad_scan_if;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [7:0] rcBits;
  modport master (output rows_n, input cols_n, input rcBits);
  modport slave (input rows_n, output cols_n, output rcBits);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with ghost rejection and press/release debounce.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DB_TICKS = 4
) (
  input logic clk,
  input logic reset,
  keypad_scan_if.slave kp
);
  typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD, RELEASE_DB} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, s2_q, col_q, col_d, cap_row_q, cap_row_d, db_cnt_q, db_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] rows_s, col_rot;
  logic tick, one_hot, db_last;
  assign rows_s = ~s2_q;
  assign tick = cnt_q == 16'(SCAN_DIV - 1);
  assign one_hot = rows_s != 4'b0 && (rows_s & (rows_s - 4'd1)) == 4'b0;
  assign db_last = db_cnt_q == 4'(DB_TICKS - 1);
  assign col_rot = {col_q[2:0], col_q[3]};
  assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  assign kp.cols_n = ~col_q;
  assign kp.rcBits = {(state_q == HOLD || state_q == RELEASE_DB) ? cap_row_q : 4'b0, col_q};
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    cap_row_d = cap_row_q;
    db_cnt_d = db_cnt_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_hot) begin
            cap_row_d = rows_s;
            db_cnt_d = 4'd1;
            state_d = DB_TICKS == 1 ? HOLD : PRESS_DB;
          end else col_d = col_rot;
        end
        PRESS_DB: begin
          if (rows_s == cap_row_q) begin
            if (db_last) state_d = HOLD;
            else db_cnt_d = db_cnt_q + 4'd1;
          end else begin
            state_d = SCAN;
            col_d = col_rot;
          end
        end
        // a single-tick debounce releases on the first quiet tick
        HOLD: begin
          if (rows_s == 4'b0) begin
            db_cnt_d = 4'd1;
            state_d = DB_TICKS == 1 ? SCAN : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (rows_s != 4'b0) state_d = HOLD;
          else if (db_last) state_d = SCAN;
          else db_cnt_d = db_cnt_q + 4'd1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
      cnt_q <= 16'd0;
      state_q <= SCAN;
      col_q <= 4'b0001;
      cap_row_q <= 4'b0;
      db_cnt_q <= 4'b0;
    end else begin
      s1_q <= kp.rows_n;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      state_q <= state_d;
      col_q <= col_d;
      cap_row_q <= cap_row_d;
      db_cnt_q <= db_cnt_d;
    end
  end
endmodule
